// File: rtl/ifu_fetch_ctrl_if.sv
// Fetch-controller bus bundle: the instruction-memory request/response channel,
// the execute redirect, and the decode handshake.
`timescale 1ns/1ps

interface ifu_fetch_ctrl_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [63:0] imem_resp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [63:0] id_pc;
    logic [31:0] id_inst;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        output id_valid,
        output id_pc,
        output id_inst,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data,
        input  redirect_valid,
        input  redirect_pc,
        input  id_ready
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        input  id_valid,
        input  id_pc,
        input  id_inst,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data,
        output redirect_valid,
        output redirect_pc,
        output id_ready
    );
endinterface

// File: rtl/ifu_fetch_ctrl.sv
// Instruction fetch sequencer: one outstanding imem request at a time, 32-bit
// instruction selected from the 64-bit response, redirects kill in-flight fetches.
`timescale 1ns/1ps

module ifu_fetch_ctrl #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic             clk,
    input  logic             rst,
    ifu_fetch_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        FLUSH = 3'd4
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [63:0] pc;
    logic [63:0] pc_next;
    logic [31:0] inst;
    logic [31:0] inst_next;
    logic [63:0] redirect_target;
    logic [31:0] resp_inst;

    assign redirect_target = {bus.redirect_pc[63:2], 2'b00};
    assign resp_inst       = pc[2] ? bus.imem_resp_data[63:32] : bus.imem_resp_data[31:0];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            pc    <= {RESET_PC[63:2], 2'b00};
            inst  <= 32'h0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            inst  <= inst_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        inst_next  = inst;

        unique case (state)
            IDLE: begin
                if (bus.redirect_valid) begin
                    pc_next = redirect_target;
                end
                state_next = REQ;
            end

            REQ: begin
                if (bus.redirect_valid) begin
                    pc_next = redirect_target;
                    // A handshake in the same cycle still launches the old
                    // address, so its response must be drained.
                    if (bus.imem_req_ready) begin
                        state_next = FLUSH;
                    end
                end else if (bus.imem_req_ready) begin
                    state_next = WAIT;
                end
            end

            WAIT: begin
                if (bus.redirect_valid) begin
                    pc_next    = redirect_target;
                    state_next = bus.imem_resp_valid ? REQ : FLUSH;
                end else if (bus.imem_resp_valid) begin
                    inst_next  = resp_inst;
                    state_next = HOLD;
                end
            end

            FLUSH: begin
                if (bus.redirect_valid) begin
                    pc_next = redirect_target;
                end
                if (bus.imem_resp_valid) begin
                    state_next = REQ;
                end
            end

            HOLD: begin
                // Redirect wins over id_ready; decode squashes the held
                // instruction on the same redirect.
                if (bus.redirect_valid) begin
                    pc_next    = redirect_target;
                    state_next = REQ;
                end else if (bus.id_ready) begin
                    pc_next    = pc + 64'd4;
                    state_next = REQ;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.imem_req_valid = (state == REQ);
    assign bus.imem_req_addr  = pc;
    assign bus.id_valid       = (state == HOLD);
    assign bus.id_pc          = pc;
    assign bus.id_inst        = inst;

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Bench for ifu_fetch_ctrl: directed cycle table, hand-written corner sequences,
// and randomized traffic against a transaction-level reference model.
`timescale 1ns/1ps

module tb_ifu_fetch_ctrl;

    localparam logic [63:0] R = 64'h0000_0000_8000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ifu_fetch_ctrl_if bus ();

    ifu_fetch_ctrl #(.RESET_PC(R)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        ready;
        logic        resp;
        logic [63:0] data;
        logic        redir;
        logic [63:0] rpc;
        logic        idr;
        logic        exp_rv;
        logic        exp_iv;
        logic [63:0] exp_pc;
        logic [31:0] exp_inst;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Memory contents: each 32-bit slot holds its own address xor a constant.
    function automatic logic [31:0] ia(input logic [63:0] a);
        return a[31:0] ^ 32'h5A5A_5A5A;
    endfunction

    function automatic logic [63:0] mw(input logic [63:0] a);
        logic [63:0] a8;
        a8 = {a[63:3], 3'b000};
        return {ia(a8 + 64'd4), ia(a8)};
    endfunction

    function automatic vec_t row(input logic ready, input logic resp, input logic [63:0] resp_addr,
                                 input logic redir, input logic [63:0] rpc, input logic idr,
                                 input logic rv, input logic iv, input logic [63:0] pc,
                                 input logic [31:0] inst);
        vec_t v;
        v.ready = ready;  v.resp = resp;  v.data = resp ? mw(resp_addr) : 64'hDEAD_BEEF_DEAD_BEEF;
        v.redir = redir;  v.rpc = rpc;    v.idr = idr;
        v.exp_rv = rv;    v.exp_iv = iv;  v.exp_pc = pc;  v.exp_inst = inst;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ready, input logic resp, input logic [63:0] data,
                         input logic redir, input logic [63:0] rpc, input logic idr);
        bus.imem_req_ready  = ready;
        bus.imem_resp_valid = resp;
        bus.imem_resp_data  = data;
        bus.redirect_valid  = redir;
        bus.redirect_pc     = rpc;
        bus.id_ready        = idr;
    endtask

    task automatic check_outputs(input string tag, input logic rv, input logic iv,
                                 input logic [63:0] pc, input logic [31:0] inst);
        check({tag, " req_valid"}, 64'(bus.imem_req_valid), 64'(rv));
        check({tag, " id_valid"},  64'(bus.id_valid),       64'(iv));
        check({tag, " req_addr"},  bus.imem_req_addr,       pc);
        check({tag, " id_pc"},     bus.id_pc,               pc);
        check({tag, " id_inst"},   64'(bus.id_inst),        64'(inst));
    endtask

    // Entered at a falling edge: drive, let one rising edge pass, check.
    task automatic apply(input vec_t v, input string tag);
        drive(v.ready, v.resp, v.data, v.redir, v.rpc, v.idr);
        @(negedge clk);
        check_outputs(tag, v.exp_rv, v.exp_iv, v.exp_pc, v.exp_inst);
    endtask

    // Reference model: tracks the fetch as a transaction (startup, outstanding
    // request, staleness, held instruction) rather than as controller states.
    logic        m_startup, m_outstanding, m_stale, m_holding;
    logic [63:0] m_pc;
    logic [31:0] m_inst;

    task automatic model_reset();
        m_startup = 1'b1;  m_outstanding = 1'b0;  m_stale = 1'b0;  m_holding = 1'b0;
        m_pc = R;  m_inst = 32'h0;
    endtask

    task automatic model_step(input logic ready, input logic resp, input logic [63:0] data,
                              input logic redir, input logic [63:0] rpc, input logic idr);
        logic [63:0] tgt;
        tgt = rpc & ~64'h3;
        if (m_startup) begin
            m_startup = 1'b0;
            if (redir) m_pc = tgt;
        end else if (m_holding) begin
            if (redir) begin
                m_pc = tgt;  m_holding = 1'b0;
            end else if (idr) begin
                m_pc = m_pc + 64'd4;  m_holding = 1'b0;
            end
        end else if (m_outstanding) begin
            if (resp) begin
                m_outstanding = 1'b0;
                if (!m_stale && !redir) begin
                    m_inst = m_pc[2] ? data[63:32] : data[31:0];
                    m_holding = 1'b1;
                end
                m_stale = 1'b0;
            end else if (redir) begin
                m_stale = 1'b1;
            end
            if (redir) m_pc = tgt;
        end else begin
            if (ready) begin
                m_outstanding = 1'b1;  m_stale = redir;
            end
            if (redir) m_pc = tgt;
        end
    endtask

    logic        r_ready, r_resp, r_redir, r_idr;
    logic [63:0] r_data, r_rpc;
    logic        mem_busy;
    int          mem_cnt;
    logic [63:0] mem_data;

    initial begin
        drive(1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);

        // Table: each row is one cycle of inputs and the outputs after its edge.
        tbl.push_back(row(0,0,0,        0,0,0, 1,0,R,        32'h0));
        tbl.push_back(row(1,0,0,        0,0,0, 0,0,R,        32'h0));
        tbl.push_back(row(1,1,R,        0,0,0, 0,1,R,        ia(R)));
        tbl.push_back(row(1,0,0,        0,0,1, 1,0,R+4,      ia(R)));
        tbl.push_back(row(1,0,0,        0,0,0, 0,0,R+4,      ia(R)));
        tbl.push_back(row(0,1,R+4,      0,0,0, 0,1,R+4,      ia(R+4)));
        tbl.push_back(row(1,0,0,        0,0,1, 1,0,R+8,      ia(R+4)));
        tbl.push_back(row(1,0,0,        0,0,0, 0,0,R+8,      ia(R+4)));
        tbl.push_back(row(1,1,R+8,      0,0,0, 0,1,R+8,      ia(R+8)));
        for (int i = 0; i < 5; i++)
            tbl.push_back(row(1,0,0,    0,0,0, 0,1,R+8,      ia(R+8)));
        tbl.push_back(row(1,0,0,        0,0,1, 1,0,R+12,     ia(R+8)));
        tbl.push_back(row(1,0,0,        0,0,0, 0,0,R+12,     ia(R+8)));
        tbl.push_back(row(0,0,0,        1,64'h8000_0103,0, 0,0,R+'h100, ia(R+8)));
        tbl.push_back(row(0,0,0,        0,0,0, 0,0,R+'h100,  ia(R+8)));
        tbl.push_back(row(0,1,R+12,     0,0,0, 1,0,R+'h100,  ia(R+8)));
        tbl.push_back(row(1,0,0,        0,0,0, 0,0,R+'h100,  ia(R+8)));
        tbl.push_back(row(1,1,R+'h100,  0,0,0, 0,1,R+'h100,  ia(R+'h100)));
        tbl.push_back(row(1,0,0,        0,0,1, 1,0,R+'h104,  ia(R+'h100)));
        tbl.push_back(row(1,0,0,        1,R+'h200,0, 0,0,R+'h200, ia(R+'h100)));
        tbl.push_back(row(0,1,R+'h104,  0,0,0, 1,0,R+'h200,  ia(R+'h100)));
        tbl.push_back(row(1,0,0,        0,0,0, 0,0,R+'h200,  ia(R+'h100)));
        tbl.push_back(row(1,1,R+'h200,  0,0,0, 0,1,R+'h200,  ia(R+'h200)));
        tbl.push_back(row(1,0,0,        1,R+'h304,1, 1,0,R+'h304, ia(R+'h200)));
        tbl.push_back(row(1,0,0,        0,0,0, 0,0,R+'h304,  ia(R+'h200)));
        tbl.push_back(row(1,1,R+'h304,  0,0,0, 0,1,R+'h304,  ia(R+'h304)));
        tbl.push_back(row(0,0,0,        0,0,1, 1,0,R+'h308,  ia(R+'h304)));
        tbl.push_back(row(0,0,0,        1,64'h8000_0402,0, 1,0,R+'h400, ia(R+'h304)));
        tbl.push_back(row(1,0,0,        0,0,0, 0,0,R+'h400,  ia(R+'h304)));
        tbl.push_back(row(0,1,R+'h400,  1,R+'h500,0, 1,0,R+'h500, ia(R+'h304)));
        tbl.push_back(row(1,0,0,        0,0,0, 0,0,R+'h500,  ia(R+'h304)));
        tbl.push_back(row(1,1,R+'h500,  0,0,0, 0,1,R+'h500,  ia(R+'h500)));
        tbl.push_back(row(0,0,0,        1,64'hFFFF_FFFF_FFFF_FFFF,0, 1,0,64'hFFFF_FFFF_FFFF_FFFC, ia(R+'h500)));
        tbl.push_back(row(1,0,0,        0,0,0, 0,0,64'hFFFF_FFFF_FFFF_FFFC, ia(R+'h500)));
        tbl.push_back(row(1,1,64'hFFFF_FFFF_FFFF_FFFC, 0,0,0, 0,1,64'hFFFF_FFFF_FFFF_FFFC,
                          ia(64'hFFFF_FFFF_FFFF_FFFC)));
        tbl.push_back(row(0,0,0,        0,0,1, 1,0,64'h0,    ia(64'hFFFF_FFFF_FFFF_FFFC)));
        tbl.push_back(row(1,0,0,        0,0,0, 0,0,64'h0,    ia(64'hFFFF_FFFF_FFFF_FFFC)));
        tbl.push_back(row(1,1,64'h0,    0,0,0, 0,1,64'h0,    ia(64'h0)));

        // Reset state.
        repeat (2) @(negedge clk);
        check_outputs("reset", 1'b0, 1'b0, R, 32'h0);
        rst = 1'b0;

        foreach (tbl[i]) apply(tbl[i], $sformatf("row%0d", i));

        // Asynchronous reset while a request is outstanding.
        apply(row(0,0,0, 0,0,1, 1,0,64'h4, ia(64'h0)), "pre_rst_req");
        apply(row(1,0,0, 0,0,0, 0,0,64'h4, ia(64'h0)), "pre_rst_wait");
        #1 rst = 1'b1;
        #1 check_outputs("async_rst", 1'b0, 1'b0, R, 32'h0);
        @(negedge clk);
        check_outputs("rst_held", 1'b0, 1'b0, R, 32'h0);
        rst = 1'b0;

        // Redirect in IDLE, then back-to-back redirects in FLUSH (later wins),
        // then a stray response in HOLD that must be ignored.
        apply(row(0,0,0, 1,64'h9000_0000,0, 1,0,64'h9000_0000, 32'h0), "idle_redir");
        apply(row(1,0,0, 0,0,0,              0,0,64'h9000_0000, 32'h0), "seq_wait");
        apply(row(0,0,0, 1,64'h9000_0010,0, 0,0,64'h9000_0010, 32'h0), "flush_redir1");
        apply(row(0,0,0, 1,64'h9000_0020,0, 0,0,64'h9000_0020, 32'h0), "flush_redir2");
        apply(row(0,1,64'h9000_0000, 0,0,0, 1,0,64'h9000_0020, 32'h0), "flush_drop");
        apply(row(1,0,0, 0,0,0,              0,0,64'h9000_0020, 32'h0), "seq_wait2");
        apply(row(1,1,64'h9000_0020, 0,0,0, 0,1,64'h9000_0020, ia(64'h9000_0020)), "seq_hold");
        apply(row(0,1,64'h9000_0000, 0,0,0, 0,1,64'h9000_0020, ia(64'h9000_0020)), "hold_stray");
        apply(row(0,0,0, 0,0,1,              1,0,64'h9000_0024, ia(64'h9000_0020)), "seq_next");

        // Randomized traffic against the reference model.
        rst = 1'b1;
        drive(1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        mem_busy = 1'b0;
        mem_cnt  = 0;
        mem_data = 64'h0;
        for (int c = 0; c < 3000; c++) begin
            check_outputs($sformatf("rand%0d", c), !m_startup && !m_outstanding && !m_holding,
                          m_holding, m_pc, m_inst);

            r_resp = 1'b0;
            r_data = {$urandom, $urandom};
            if (mem_busy) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    r_resp   = 1'b1;
                    r_data   = mem_data;
                    mem_busy = 1'b0;
                end
            end
            r_ready = ($urandom_range(0, 2) != 0);
            r_redir = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 9))
                0:       r_rpc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
                1, 2:    r_rpc = {$urandom, $urandom};
                default: r_rpc = {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_FFFF)};
            endcase
            r_idr = 1'($urandom_range(0, 1));

            if (bus.imem_req_valid && r_ready) begin
                mem_busy = 1'b1;
                mem_cnt  = $urandom_range(1, 3);
                mem_data = mw(bus.imem_req_addr);
            end

            drive(r_ready, r_resp, r_data, r_redir, r_rpc, r_idr);
            model_step(r_ready, r_resp, r_data, r_redir, r_rpc, r_idr);
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
